// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded instruction per
// transaction, translates ALUOp/funct into the 4-bit ALU opcode, drives the
// neighbouring combinational ALU from registered operands, captures its
// result one cycle later and presents it downstream with the branch outcome.
module alu_issue_ctrl #(
   parameter int         WIDTH      = 32,
   parameter logic [3:0] OP_ILLEGAL = 4'b1111
) (
   input  logic             clk,
   input  logic             rst,
   // decode side
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             is_rtype,
   input  logic [WIDTH-1:0] rs1_val,
   input  logic [WIDTH-1:0] rs2_val,
   // ALU side
   output logic [WIDTH-1:0] alu_inp1,
   output logic [WIDTH-1:0] alu_inp2,
   output logic [3:0]       alu_op_choice,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   // memory/writeback side
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_br_taken,
   output logic             out_illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t state, state_next;

   logic       accept;
   logic [3:0] dec_op;
   logic       dec_illegal;
   logic       dec_branch;
   logic       illegal_q;
   logic       branch_q;
   logic       bne_q;

   // Ready is withheld while reset is asserted so nothing transfers into a
   // block that is being cleared; in RESP a new op may enter only as the
   // current result leaves.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    in_ready = 1'b1;
            RESP:    in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept    = in_valid & in_ready;
   assign out_valid = (state == RESP);

   // Decode ALUOp/funct3 into the ALU opcode, illegal flag and branch flag.
   // NOTE: every output gets a default before the case so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      dec_branch  = 1'b0;
      case (alu_op)
         2'b00: dec_op = OP_ADD;
         2'b01: begin
            // Branch compare is a subtract; only BEQ/BNE are supported.
            dec_op      = OP_SUB;
            dec_branch  = 1'b1;
            dec_illegal = (funct3 != 3'b000) && (funct3 != 3'b001);
         end
         2'b10: begin
            case (funct3)
               3'b000:  dec_op = (is_rtype && funct7_5) ? OP_SUB : OP_ADD;
               3'b111:  dec_op = OP_AND;
               3'b110:  dec_op = OP_OR;
               default: begin
                  dec_op      = OP_ILLEGAL;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         default: begin
            dec_op      = OP_ILLEGAL;
            dec_illegal = 1'b1;
         end
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic for the IDLE -> EXEC -> RESP handshake loop.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP: begin
            if (out_ready) state_next = accept ? EXEC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Register operands, opcode and decode side-info on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_inp1      <= '0;
         alu_inp2      <= '0;
         alu_op_choice <= 4'b0000;
         illegal_q     <= 1'b0;
         branch_q      <= 1'b0;
         bne_q         <= 1'b0;
      end else if (accept) begin
         alu_inp1      <= rs1_val;
         alu_inp2      <= rs2_val;
         alu_op_choice <= dec_op;
         illegal_q     <= dec_illegal;
         branch_q      <= dec_branch;
         bne_q         <= funct3[0];
      end
   end

   // Capture the settled ALU outputs at the end of EXEC; they are held
   // untouched through RESP so they stay stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_result   <= '0;
         out_zero     <= 1'b0;
         out_br_taken <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (state == EXEC) begin
         // Illegal ops report a zero result whatever opcode reached the ALU.
         out_result   <= illegal_q ? '0 : alu_result;
         out_zero     <= illegal_q | alu_zero;
         out_br_taken <= branch_q & ~illegal_q & (bne_q ? ~alu_zero : alu_zero);
         out_illegal  <= illegal_q;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU
// placed beside the DUT, as in the real execute stage.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_op;
   logic [2:0]       funct3;
   logic             funct7_5;
   logic             is_rtype;
   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;
   logic [WIDTH-1:0] alu_inp1;
   logic [WIDTH-1:0] alu_inp2;
   logic [3:0]       alu_op_choice;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_br_taken;
   logic             out_illegal;

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_ctrl #(.WIDTH(WIDTH), .OP_ILLEGAL(4'b1111)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_op        (alu_op),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .is_rtype      (is_rtype),
      .rs1_val       (rs1_val),
      .rs2_val       (rs2_val),
      .alu_inp1      (alu_inp1),
      .alu_inp2      (alu_inp2),
      .alu_op_choice (alu_op_choice),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_zero      (out_zero),
      .out_br_taken  (out_br_taken),
      .out_illegal   (out_illegal)
   );

   // Behavioural ALU: and/or/add/sub, anything else returns 0.
   always_comb begin
      case (alu_op_choice)
         4'b0000: alu_result = alu_inp1 & alu_inp2;
         4'b0001: alu_result = alu_inp1 | alu_inp2;
         4'b0010: alu_result = alu_inp1 + alu_inp2;
         4'b0110: alu_result = alu_inp1 - alu_inp2;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction, check the EXEC cycle, then the RESP cycle.
   // Leaves the DUT in RESP; the caller decides when out_ready drains it.
   task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic rt,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] exp_op, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_br, input logic exp_ill);
      alu_op   = op;
      funct3   = f3;
      funct7_5 = f75;
      is_rtype = rt;
      rs1_val  = a;
      rs2_val  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rs1_val  = 32'hDEAD_BEEF;
      rs2_val  = 32'hDEAD_BEEF;
      check({tag, ".exec_opc"},   32'(alu_op_choice), 32'(exp_op));
      check({tag, ".exec_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".exec_ready"}, 32'(in_ready), 32'd0);
      tick();
      check({tag, ".valid"},   32'(out_valid), 32'd1);
      check({tag, ".result"},  out_result, exp_res);
      check({tag, ".zero"},    32'(out_zero), 32'(exp_zero));
      check({tag, ".br"},      32'(out_br_taken), 32'(exp_br));
      check({tag, ".illegal"}, 32'(out_illegal), 32'(exp_ill));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      alu_op    = 2'b00;
      funct3    = 3'b000;
      funct7_5  = 1'b0;
      is_rtype  = 1'b0;
      rs1_val   = '0;
      rs2_val   = '0;
      out_ready = 1'b1;

      // Reset state.
      tick();
      check("rst.in_ready",  32'(in_ready), 32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.opc",       32'(alu_op_choice), 32'd0);
      check("rst.result",    out_result, 32'd0);
      rst = 1'b0;
      #1;
      check("idle.in_ready", 32'(in_ready), 32'd1);

      // ADD 5 + 7.
      issue("add", 2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);
      check("add.resp_ready", 32'(in_ready), 32'd1);
      tick();
      check("add.drained", 32'(out_valid), 32'd0);
      check("add.idle_ready", 32'(in_ready), 32'd1);

      // SUB wraps; the I-type form of the same funct bits adds instead.
      issue("sub", 2'b10, 3'b000, 1'b1, 1'b1, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      tick();
      issue("addi", 2'b10, 3'b000, 1'b1, 1'b0, 32'd0, 32'd1, 4'b0010, 32'd1, 1'b0, 1'b0, 1'b0);
      tick();

      // BEQ / BNE on equal operands.
      issue("beq", 2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b1, 1'b0);
      tick();
      issue("bne", 2'b01, 3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);
      tick();
      // BNE on unequal operands is taken.
      issue("bne_tk", 2'b01, 3'b001, 1'b0, 1'b0, 32'd9, 32'd4, 4'b0110, 32'd5, 1'b0, 1'b1, 1'b0);
      tick();

      // Illegal funct3 under R/I-type, and reserved ALUOp.
      issue("ill_f3", 2'b10, 3'b100, 1'b0, 1'b1, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
      tick();
      issue("ill_op", 2'b11, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
      tick();

      // Backpressure: AND result held for 4 cycles with out_ready low.
      out_ready = 1'b0;
      issue("and", 2'b10, 3'b111, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000,
            32'h0000_F000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("bp.in_ready", 32'(in_ready), 32'd0);
         tick();
         check("bp.valid",  32'(out_valid), 32'd1);
         check("bp.result", out_result, 32'h0000_F000);
      end

      // Release with a new op waiting: accepted in the same cycle.
      out_ready = 1'b1;
      alu_op    = 2'b10;
      funct3    = 3'b110;
      funct7_5  = 1'b0;
      is_rtype  = 1'b1;
      rs1_val   = 32'h0000_000F;
      rs2_val   = 32'h0000_00F0;
      in_valid  = 1'b1;
      #1;
      check("b2b.in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("b2b.exec_valid", 32'(out_valid), 32'd0);
      check("b2b.exec_opc",   32'(alu_op_choice), 32'd1);
      tick();
      check("b2b.valid",  32'(out_valid), 32'd1);
      check("b2b.result", out_result, 32'h0000_00FF);
      tick();
      check("b2b.drained", 32'(out_valid), 32'd0);

      // Reset asserted asynchronously while an op is in EXEC.
      alu_op   = 2'b00;
      rs1_val  = 32'd100;
      rs2_val  = 32'd23;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rstx.exec_opc", 32'(alu_op_choice), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check("rstx.valid",    32'(out_valid), 32'd0);
      check("rstx.opc",      32'(alu_op_choice), 32'd0);
      check("rstx.in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rstx.rel_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstx.no_stale", 32'(out_valid), 32'd0);
      end
      check("rstx.result", out_result, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
